// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing one register bus between NUM_REQ requesters.
// One transaction in flight; reads are captured from the slave or time out with all-ones data.

module reg_access_lane (
  input  logic wren,
  input  logic rden,
  input  logic sel,
  input  logic rd,
  input  logic err,
  output logic pend,
  output logic ack,
  output logic rvld,
  output logic rerr
);
  assign pend = wren | rden;
  assign ack  = sel;
  assign rvld = sel & rd & ~err;
  assign rerr = sel & err;
endmodule

module reg_access_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_wren,
  input  logic [NUM_REQ-1:0]            req_rden,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdat,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_rvld,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [DATA_WIDTH-1:0]         req_rdat,
  output logic [ADDR_WIDTH-1:0]         user_addr,
  output logic                          user_wren,
  output logic [DATA_WIDTH-1:0]         user_wdat,
  output logic                          user_rden,
  input  logic [DATA_WIDTH-1:0]         user_rdat,
  input  logic                          user_rvld
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_arr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdat_arr;
  logic [NUM_REQ-1:0]                 pend;
  logic [PW-1:0]                      ptr, gnt_idx;
  logic [PW:0]                        cand;
  logic                               gnt_vld;
  logic                               op_wr, op_rd, op_err;
  logic [CW-1:0]                      cnt;
  logic [ADDR_WIDTH-1:0]              addr_q;
  logic [DATA_WIDTH-1:0]              wdat_q, rdat_q;

  assign addr_arr = req_addr;
  assign wdat_arr = req_wdat;

  // ptr holds the index of the current/last grant, so it also selects the ack lane
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    reg_access_lane u_lane (
      .wren (req_wren[i]),
      .rden (req_rden[i]),
      .sel  ((state == RESP) && (ptr == PW'(i))),
      .rd   (op_rd),
      .err  (op_err),
      .pend (pend[i]),
      .ack  (req_ack[i]),
      .rvld (req_rvld[i]),
      .rerr (req_err[i])
    );
  end

  // Scan from farthest to nearest so the first pending index after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
      if (pend[cand[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = (!op_rd || user_rvld) ? RESP : WAIT;
      WAIT:    if (user_rvld || cnt == CW'(TIMEOUT)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= PW'(NUM_REQ - 1);
      addr_q <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
      op_wr  <= 1'b0;
      op_rd  <= 1'b0;
      op_err <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          ptr    <= gnt_idx;
          addr_q <= addr_arr[gnt_idx];
          wdat_q <= wdat_arr[gnt_idx];
          op_wr  <= req_wren[gnt_idx];
          op_rd  <= req_rden[gnt_idx];
          op_err <= 1'b0;
        end
        ISSUE: if (op_rd) begin
          if (user_rvld) rdat_q <= user_rdat;
          else           cnt    <= CW'(1);
        end
        // data arriving on the last allowed cycle beats the timeout
        WAIT: begin
          if (user_rvld) rdat_q <= user_rdat;
          else if (cnt == CW'(TIMEOUT)) begin
            rdat_q <= {DATA_WIDTH{1'b1}};
            op_err <= 1'b1;
          end else cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign user_addr = addr_q;
  assign user_wdat = wdat_q;
  assign user_wren = (state == ISSUE) & op_wr;
  assign user_rden = (state == ISSUE) & op_rd;
  assign req_rdat  = rdat_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: table of single transactions plus
// hand-written reset-abort and round-robin sequences.

module tb_reg_access_arbiter;
  localparam int NR = 2, DW = 32, AW = 32, TO = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req_wren, req_rden, req_ack, req_rvld, req_err;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0][DW-1:0]  req_wdat;
  logic [DW-1:0]          req_rdat, user_wdat, user_rdat;
  logic [AW-1:0]          user_addr;
  logic                   user_wren, user_rden, user_rvld;
  int                     checks = 0, errors = 0;

  always #5 clk = ~clk;

  reg_access_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_wren(req_wren), .req_rden(req_rden), .req_addr(req_addr), .req_wdat(req_wdat),
    .req_ack(req_ack), .req_rvld(req_rvld), .req_err(req_err), .req_rdat(req_rdat),
    .user_addr(user_addr), .user_wren(user_wren), .user_wdat(user_wdat),
    .user_rden(user_rden), .user_rdat(user_rdat), .user_rvld(user_rvld)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // dly: cycles from user_rden to user_rvld (-1 = slave never answers)
  // junk: pulse user_rvld alongside a write strobe (must be ignored)
  // lat: cycles from grant (request cycle) to ack
  typedef struct {
    int          r;
    bit          wr, rd;
    logic [31:0] addr, wdat;
    int          dly;
    logic [31:0] sdat;
    bit          junk;
    int          lat;
    bit          rv, er;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl[9];

  task automatic run_vec(input vec_t v, input int n);
    int          rden_cyc = -1, wcnt = 0, rcnt = 0;
    bit          done = 0;
    logic [1:0]  oh;
    oh = 2'b01 << v.r;
    req_addr[v.r] = v.addr;
    req_wdat[v.r] = v.wdat;
    req_wren[v.r] = v.wr;
    req_rden[v.r] = v.rd;
    for (int c = 0; c < 40 && !done; c++) begin
      if (user_wren) begin
        wcnt++;
        chk($sformatf("v%0d wr_addr", n), user_addr, v.addr);
        chk($sformatf("v%0d wr_data", n), user_wdat, v.wdat);
      end
      if (user_rden) begin
        rcnt++;
        rden_cyc = c;
        chk($sformatf("v%0d rd_addr", n), user_addr, v.addr);
      end
      user_rvld = 1'b0;
      if (v.dly >= 0 && rden_cyc >= 0 && c - rden_cyc == v.dly) begin
        user_rvld = 1'b1;
        user_rdat = v.sdat;
      end
      if (v.junk && user_wren) begin
        user_rvld = 1'b1;
        user_rdat = 32'hBAD;
      end
      if (req_ack != '0) begin
        done = 1;
        chk($sformatf("v%0d latency", n), c, v.lat);
        chk($sformatf("v%0d ack", n), {30'b0, req_ack}, {30'b0, oh});
        chk($sformatf("v%0d rvld", n), {30'b0, req_rvld}, v.rv ? {30'b0, oh} : 32'h0);
        chk($sformatf("v%0d err", n), {30'b0, req_err}, v.er ? {30'b0, oh} : 32'h0);
        if (v.rd) chk($sformatf("v%0d rdat", n), req_rdat, v.rdat);
        chk($sformatf("v%0d n_wren", n), wcnt, v.wr);
        chk($sformatf("v%0d n_rden", n), rcnt, v.rd);
        req_wren = '0;
        req_rden = '0;
      end
      tick;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL v%0d ack: got none expected ack within 40 cycles", n);
      req_wren = '0;
      req_rden = '0;
    end
    user_rvld = 1'b0;
    chk($sformatf("v%0d rdat_hold", n), req_rdat, v.rdat);
    chk($sformatf("v%0d ack_single", n), {30'b0, req_ack}, 32'h0);
    tick;
  endtask

  initial begin
    int          acks, wcnt, last_ack, spur;
    logic [31:0] last_addr;
    logic [1:0]  oh;

    //            r  wr rd addr        wdat        dly sdat        junk lat rv er rdat
    tbl[0] = '{0, 1, 0, 32'h10, 32'hA5,        -1, 32'h0,      0,   2,  0, 0, 32'h0};
    tbl[1] = '{1, 0, 1, 32'h20, 32'h0,          3, 32'h1234,   0,   5,  1, 0, 32'h1234};
    tbl[2] = '{0, 0, 1, 32'h30, 32'h0,          0, 32'hCAFE,   0,   2,  1, 0, 32'hCAFE};
    tbl[3] = '{1, 1, 0, 32'h44, 32'hDEAD,      -1, 32'h0,      1,   2,  0, 0, 32'hCAFE};
    tbl[4] = '{0, 0, 1, 32'h34, 32'h0,         -1, 32'h0,      0,  18,  0, 1, 32'hFFFF_FFFF};
    tbl[5] = '{1, 0, 1, 32'h38, 32'h0,         16, 32'h5555,   0,  18,  1, 0, 32'h5555};
    tbl[6] = '{0, 0, 1, 32'h3C, 32'h0,         17, 32'h6666,   0,  18,  0, 1, 32'hFFFF_FFFF};
    tbl[7] = '{1, 1, 1, 32'h50, 32'h99,         0, 32'h77,     0,   2,  1, 0, 32'h77};
    tbl[8] = '{0, 0, 1, 32'h54, 32'h0,          1, 32'h0F0F,   0,   3,  1, 0, 32'h0F0F};

    rst_n = 1'b0;
    req_wren = '0; req_rden = '0; req_addr = '0; req_wdat = '0;
    user_rvld = 1'b0; user_rdat = '0;
    #1;
    chk("rst outputs", {req_ack, req_rvld, req_err, 25'b0, user_wren, user_rden}, 32'h0);
    chk("rst user_addr", user_addr, 32'h0);
    chk("rst req_rdat", req_rdat, 32'h0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // reset while a read sits in WAIT: immediate clear, no ack afterwards
    req_addr[1] = 32'h60;
    req_rden[1] = 1'b1;
    tick;
    chk("abort rden", {31'b0, user_rden}, 32'h1);
    tick; tick;
    rst_n = 1'b0;
    #1;
    chk("abort outputs", {req_ack, req_rvld, req_err, 25'b0, user_wren, user_rden}, 32'h0);
    chk("abort user_addr", user_addr, 32'h0);
    chk("abort req_rdat", req_rdat, 32'h0);
    req_rden = '0;
    tick; tick;
    rst_n = 1'b1;
    spur = 0;
    for (int c = 0; c < 5; c++) begin
      if (req_ack != '0) spur++;
      tick;
    end
    chk("abort no_ack", spur, 0);

    // both requesters hold writes: grants 0,1,0,1, one strobe per ack, 3-cycle spacing
    req_addr[0] = 32'h100; req_wdat[0] = 32'h1;
    req_addr[1] = 32'h200; req_wdat[1] = 32'h2;
    req_wren = 2'b11;
    acks = 0; wcnt = 0; last_ack = 0; last_addr = '0;
    for (int c = 0; c < 30 && acks < 4; c++) begin
      if (user_wren) begin
        wcnt++;
        last_addr = user_addr;
      end
      if (req_ack != '0) begin
        oh = 2'b01 << (acks % 2);
        chk($sformatf("rr ack%0d", acks), {30'b0, req_ack}, {30'b0, oh});
        chk($sformatf("rr wren_cnt%0d", acks), wcnt, 1);
        chk($sformatf("rr addr%0d", acks), last_addr, (acks % 2) ? 32'h200 : 32'h100);
        chk($sformatf("rr spacing%0d", acks), c - last_ack, (acks == 0) ? 2 : 3);
        last_ack = c;
        wcnt = 0;
        acks++;
      end
      tick;
    end
    chk("rr ack_count", acks, 4);
    req_wren = '0;
    tick; tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
